// File: rtl/nand_async_cmd_seq.sv
// nand_async_cmd_seq
// ONFI SDR async-mode command/address latch sequencer feeding the NAND PHY.
// Each accepted byte is driven onto DQ with CLE or ALE for T_SETUP cycles.
// WE# is then pulsed low for T_WP cycles and held high for T_WH cycles.
// CE# stays asserted across a burst until the byte flagged req_last.
// Optional build macro NAND_SEQ_TIMEOUT_EN adds a watchdog on the HOLD state.
// With the macro, a burst left idle for TIMEOUT cycles is released and flagged.
// Timing parameters of 0 are treated as 1.

module nand_async_cmd_seq #(
    parameter int T_SETUP = 2,
    parameter int T_WP    = 3,
    parameter int T_WH    = 2,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic       v_clk0,
    input  logic       v_rstn0,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_is_addr,
    input  logic [7:0] req_byte,
    input  logic       req_last,
    input  logic       ce_sel,
    input  logic       wp_n,
    output logic       ctrl_cle,
    output logic       ctrl_ale,
    output logic       ctrl_wen,
    output logic       ctrl_wen_sel,
    output logic       ctrl_wrn,
    output logic       ctrl_wpn,
    output logic [1:0] ctrl_cen,
    output logic       dq_oe_n,
    output logic [7:0] wr_data_rise,
    output logic [7:0] wr_data_fall,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    // Effective phase lengths: zero is promoted to one so every phase exists.
    localparam int T_SETUP_EFF = (T_SETUP < 1) ? 1 : T_SETUP;
    localparam int T_WP_EFF    = (T_WP    < 1) ? 1 : T_WP;
    localparam int T_WH_EFF    = (T_WH    < 1) ? 1 : T_WH;

    localparam logic [CNT_W-1:0] SETUP_LOAD = T_SETUP_EFF[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WP_LOAD    = T_WP_EFF[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WH_LOAD    = T_WH_EFF[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WE_LOW,
        S_WE_HIGH,
        S_HOLD,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_q, last_d;

    logic             cle_d, ale_d, wen_d, oe_n_d;
    logic [1:0]       cen_d;
    logic [7:0]       data_d;
    logic             busy_d, done_d, ready_d;
    logic             accept;

`ifdef NAND_SEQ_TIMEOUT_EN
    // Watchdog is at least CNT_W+3 bits, widened if TIMEOUT needs more.
    localparam int TIMEOUT_EFF = (TIMEOUT < 1) ? 1 : TIMEOUT;
    localparam int WD_MIN_W    = CNT_W + 3;
    localparam int WD_FIT_W    = $clog2(TIMEOUT_EFF + 1);
    localparam int WD_W        = (WD_FIT_W > WD_MIN_W) ? WD_FIT_W : WD_MIN_W;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_EFF - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_flag_q, to_flag_d;
    logic            terr_d;
`endif

    assign accept = req_valid & req_ready;

    // Next-state and next-output decode for the byte sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        cle_d   = ctrl_cle;
        ale_d   = ctrl_ale;
        wen_d   = ctrl_wen;
        oe_n_d  = dq_oe_n;
        cen_d   = ctrl_cen;
        data_d  = wr_data_rise;
        done_d  = 1'b0;
`ifdef NAND_SEQ_TIMEOUT_EN
        wd_d      = wd_q;
        to_flag_d = to_flag_q;
        terr_d    = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_SETUP;
                    cen_d   = ce_sel ? 2'b01 : 2'b10;
                end
            end

            S_SETUP: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_WE_LOW;
                    cnt_d   = WP_LOAD;
                    wen_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_WE_LOW: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = S_WE_HIGH;
                    cnt_d   = WH_LOAD;
                    wen_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_WE_HIGH: begin
                if (cnt_q == CNT_ONE) begin
                    state_d = last_q ? S_RELEASE : S_HOLD;
                    cnt_d   = '0;
                    cle_d   = 1'b0;
                    ale_d   = 1'b0;
                    oe_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            S_HOLD: begin
                // CE# stays asserted; the chip select latched at burst start is kept.
                if (accept) begin
                    state_d = S_SETUP;
                end
`ifdef NAND_SEQ_TIMEOUT_EN
                else if (wd_q == WD_LAST) begin
                    state_d   = S_RELEASE;
                    to_flag_d = 1'b1;
                end
`endif
            end

            S_RELEASE: begin
                // One cycle of tCH with CE# still low, then release the target.
                state_d = S_IDLE;
                cen_d   = 2'b11;
`ifdef NAND_SEQ_TIMEOUT_EN
                if (to_flag_q) begin
                    terr_d    = 1'b1;
                    to_flag_d = 1'b0;
                end else begin
                    done_d = 1'b1;
                end
`else
                done_d = 1'b1;
`endif
            end

            default: begin
                state_d = S_IDLE;
                cen_d   = 2'b11;
            end
        endcase

        // Common byte load for accepts taken from IDLE or HOLD.
        if (accept) begin
            cnt_d  = SETUP_LOAD;
            last_d = req_last;
            cle_d  = ~req_is_addr;
            ale_d  = req_is_addr;
            data_d = req_byte;
            oe_n_d = 1'b0;
            wen_d  = 1'b1;
        end

`ifdef NAND_SEQ_TIMEOUT_EN
        // Watchdog counts HOLD cycles and restarts on every accepted byte.
        if (accept) begin
            wd_d = '0;
        end else if (state_q == S_HOLD) begin
            wd_d = (wd_q == WD_LAST) ? '0 : wd_q + 1'b1;
        end
`endif

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE) || (state_d == S_HOLD);
    end

    // State register and registered PHY-side outputs.
    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            // NOTE: an async reset must release CE# and WE# immediately, so every flop is reset here.
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            ctrl_cle     <= 1'b0;
            ctrl_ale     <= 1'b0;
            ctrl_wen     <= 1'b1;
            ctrl_wen_sel <= 1'b1;
            ctrl_wrn     <= 1'b1;
            ctrl_wpn     <= 1'b0;
            ctrl_cen     <= 2'b11;
            dq_oe_n      <= 1'b1;
            wr_data_rise <= 8'h00;
            wr_data_fall <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
            req_ready    <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            ctrl_cle     <= cle_d;
            ctrl_ale     <= ale_d;
            ctrl_wen     <= wen_d;
            ctrl_wen_sel <= 1'b1;
            ctrl_wrn     <= 1'b1;
            ctrl_wpn     <= wp_n;
            ctrl_cen     <= cen_d;
            dq_oe_n      <= oe_n_d;
            wr_data_rise <= data_d;
            wr_data_fall <= data_d;
            busy         <= busy_d;
            done         <= done_d;
            req_ready    <= ready_d;
        end
    end

`ifdef NAND_SEQ_TIMEOUT_EN
    // Watchdog counter, timeout flag and the timeout pulse.
    always_ff @(posedge v_clk0 or negedge v_rstn0) begin
        if (!v_rstn0) begin
            wd_q        <= '0;
            to_flag_q   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            wd_q        <= wd_d;
            to_flag_q   <= to_flag_d;
            timeout_err <= terr_d;
        end
    end
`else
    // Without the watchdog, HOLD waits indefinitely and never reports a timeout.
    assign timeout_err = 1'b0;
`endif

endmodule
